// File: rtl/spi_cfg_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_cfg_master
// Function : Round-robin arbitrated SPI write master for the PWM/output-enable
//            register file. It sends one 16-bit write frame per request,
//            MSB first, using SPI mode 0.
// Revision : 1.0 - initial release
// ============================================================================

module spi_cfg_master #(
    parameter int HALF_PERIOD = 4,
    parameter int GAP_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [6:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [6:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       nCS,
    output logic       SCLK,
    output logic       COPI,
    output logic       busy,
    output logic       done,
    output logic       done_id
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam logic [7:0] c_half_load = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] c_gap_load  = 8'(GAP_CYCLES - 1);
    localparam logic [4:0] c_last_bit  = 5'd16;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_phase_cnt;
    logic [7:0]  w_phase_cnt_nxt;
    logic [4:0]  r_bit_cnt;
    logic [4:0]  w_bit_cnt_nxt;
    logic [4:0]  w_bit_inc;
    logic [15:0] r_shift;
    logic [15:0] w_shift_nxt;
    logic        r_rr_ptr;
    logic        w_rr_ptr_nxt;
    logic        r_id;
    logic        w_id_nxt;
    logic        r_ncs;
    logic        w_ncs_nxt;
    logic        r_sclk;
    logic        w_sclk_nxt;
    logic        r_busy;
    logic        r_done;
    logic        w_done_nxt;
    logic        r_done_id;
    logic        w_done_id_nxt;

    logic        w_idle;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_handshake;
    logic        w_phase_done;
    logic [15:0] w_frame;

    // r_rr_ptr names the requester preferred when both are valid.
    assign w_idle       = (r_state == ST_IDLE);
    assign w_grant0     = req0_valid & (~req1_valid | ~r_rr_ptr);
    assign w_grant1     = req1_valid & (~req0_valid |  r_rr_ptr);
    assign req0_ready   = w_idle & w_grant0;
    assign req1_ready   = w_idle & w_grant1;
    assign w_handshake  = req0_ready | req1_ready;
    assign w_phase_done = (r_phase_cnt == 8'd0);
    assign w_bit_inc    = r_bit_cnt + 5'd1;
    assign w_frame      = req1_ready ? {1'b1, req1_addr, req1_data}
                                     : {1'b1, req0_addr, req0_data};

    assign nCS     = r_ncs;
    assign SCLK    = r_sclk;
    assign COPI    = r_shift[15];
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_phase_cnt <= 8'd0;
            r_bit_cnt   <= 5'd0;
            r_shift     <= 16'd0;
            r_rr_ptr    <= 1'b0;
            r_id        <= 1'b0;
            r_ncs       <= 1'b1;
            r_sclk      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_done_id   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase_cnt <= w_phase_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_id        <= w_id_nxt;
            r_ncs       <= w_ncs_nxt;
            r_sclk      <= w_sclk_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= w_done_nxt;
            r_done_id   <= w_done_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_phase_cnt_nxt = r_phase_cnt;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_id_nxt        = r_id;
        w_ncs_nxt       = r_ncs;
        w_sclk_nxt      = r_sclk;
        w_done_nxt      = 1'b0;
        w_done_id_nxt   = r_done_id;

        case (r_state)
            ST_IDLE: begin
                if (w_handshake) begin
                    w_state_nxt     = ST_SETUP;
                    w_shift_nxt     = w_frame;
                    w_id_nxt        = req1_ready;
                    w_rr_ptr_nxt    = req0_ready;
                    w_phase_cnt_nxt = c_half_load;
                    w_bit_cnt_nxt   = 5'd0;
                    w_ncs_nxt       = 1'b0;
                    w_sclk_nxt      = 1'b0;
                end
            end

            ST_SETUP: begin
                if (w_phase_done) begin
                    w_state_nxt     = ST_HIGH;
                    w_phase_cnt_nxt = c_half_load;
                    w_sclk_nxt      = 1'b1;
                end else begin
                    w_phase_cnt_nxt = r_phase_cnt - 8'd1;
                end
            end

            ST_HIGH: begin
                if (w_phase_done) begin
                    w_state_nxt     = ST_LOW;
                    w_phase_cnt_nxt = c_half_load;
                    w_sclk_nxt      = 1'b0;
                    w_bit_cnt_nxt   = w_bit_inc;
                    // Bit 0 is held on COPI through the final LOW phase.
                    if (w_bit_inc != c_last_bit) begin
                        w_shift_nxt = {r_shift[14:0], 1'b0};
                    end
                end else begin
                    w_phase_cnt_nxt = r_phase_cnt - 8'd1;
                end
            end

            ST_LOW: begin
                if (w_phase_done) begin
                    if (r_bit_cnt == c_last_bit) begin
                        w_state_nxt     = ST_GAP;
                        w_phase_cnt_nxt = c_gap_load;
                        w_ncs_nxt       = 1'b1;
                        w_shift_nxt     = 16'd0;
                        w_done_nxt      = 1'b1;
                        w_done_id_nxt   = r_id;
                    end else begin
                        w_state_nxt     = ST_HIGH;
                        w_phase_cnt_nxt = c_half_load;
                        w_sclk_nxt      = 1'b1;
                    end
                end else begin
                    w_phase_cnt_nxt = r_phase_cnt - 8'd1;
                end
            end

            ST_GAP: begin
                if (w_phase_done) begin
                    w_state_nxt     = ST_IDLE;
                    w_phase_cnt_nxt = 8'd0;
                end else begin
                    w_phase_cnt_nxt = r_phase_cnt - 8'd1;
                end
            end

            default: begin
                w_state_nxt     = ST_IDLE;
                w_phase_cnt_nxt = 8'd0;
                w_shift_nxt     = 16'd0;
                w_ncs_nxt       = 1'b1;
                w_sclk_nxt      = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire
